timer_io: RTL and testbench

TIMER_IO -- requirements
Module: timer_io

---
 rtl/timer_io.sv | 138 +++++++++++++
 tb/tb_timer_io.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_io.sv
// Memory-mapped down-counting timer with prescaler, one-shot/auto-reload modes and a sticky DONE flag.
// Optional interrupt output Irq is built when the macro TIMER_IO_IRQ_EN is defined.
module timer_io #(
  parameter int PRESCALE = 50000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic        cs,
  output logic [15:0] Q,
  output logic        Done
`ifdef TIMER_IO_IRQ_EN
  ,
  output logic        Irq
`endif
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] load_q;
  logic [15:0] count_q;
  logic [15:0] ps_q;
  logic        en_q;
  logic        auto_q;
  logic        ie_q;
  logic        done_q;

  logic        wr;
  logic [1:0]  sel;
  logic        wr_load;
  logic        wr_ctrl;
  logic        wr_status;
  logic        tick;
  logic        take_tick;
  logic        expire;
  logic        unused_addr;

  assign cs          = (ADDR[15:12] == 4'h4);
  assign sel         = ADDR[1:0];
  assign unused_addr = &{1'b0, ADDR[11:2]};
  assign wr          = cs & W;
  assign wr_load     = wr & (sel == 2'd0);
  assign wr_ctrl     = wr & (sel == 2'd2);
  assign wr_status   = wr & (sel == 2'd3);

  // A LOAD or CTRL write landing on a tick edge swallows that tick entirely.
  assign tick      = en_q && (ps_q == PS_LAST);
  assign take_tick = tick & ~wr_load & ~wr_ctrl;
  assign expire    = take_tick && (count_q <= 16'd1);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ps_q <= '0;
    end else if (wr_ctrl || !en_q || tick) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + 16'd1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      load_q <= '0;
    end else if (wr_load) begin
      load_q <= DOUT;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count_q <= '0;
    end else if (wr_load) begin
      count_q <= DOUT;
    end else if (take_tick) begin
      if (count_q > 16'd1) begin
        count_q <= count_q - 16'd1;
      end else if (auto_q) begin
        count_q <= load_q;
      end else begin
        count_q <= '0;
      end
    end
  end

  // EN is the only run/stop state: set by software, cleared by a one-shot expiry.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      en_q   <= 1'b0;
      auto_q <= 1'b0;
    end else if (wr_ctrl) begin
      en_q   <= DOUT[0];
      auto_q <= DOUT[1];
    end else if (expire && !auto_q) begin
      en_q   <= 1'b0;
    end
  end

`ifdef TIMER_IO_IRQ_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ie_q <= 1'b0;
    end else if (wr_ctrl) begin
      ie_q <= DOUT[2];
    end
  end

  assign Irq = done_q & ie_q;
`else
  assign ie_q = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      done_q <= 1'b0;
    end else if (expire) begin
      done_q <= 1'b1;
    end else if (wr_status) begin
      done_q <= 1'b0;
    end
  end

  assign Done = done_q;

  always_comb begin
    Q = 16'h0000;
    if (cs) begin
      case (sel)
        2'd0:    Q = load_q;
        2'd1:    Q = count_q;
        2'd2:    Q = {13'd0, ie_q, auto_q, en_q};
        default: Q = {15'd0, done_q};
      endcase
    end
  end

endmodule

// File: tb/tb_timer_io.sv
// Directed self-checking bench for timer_io with PRESCALE = 4.
// Define TIMER_IO_IRQ_EN for both files to exercise the Irq output.
`timescale 1ns/100ps
module tb_timer_io;

  logic        Clock;
  logic        Resetn;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic        cs;
  logic [15:0] Q;
  logic        Done;
`ifdef TIMER_IO_IRQ_EN
  logic        Irq;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] A_LOAD   = 16'h4000;
  localparam logic [15:0] A_COUNT  = 16'h4001;
  localparam logic [15:0] A_CTRL   = 16'h4002;
  localparam logic [15:0] A_STATUS = 16'h4003;

  timer_io #(.PRESCALE(4)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .ADDR  (ADDR),
    .DOUT  (DOUT),
    .W     (W),
    .cs    (cs),
    .Q     (Q),
    .Done  (Done)
`ifdef TIMER_IO_IRQ_EN
    ,
    .Irq   (Irq)
`endif
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  // Write lands on the rising edge following the next falling edge; returns 1ns after it.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data);
    @(negedge Clock);
    ADDR = addr;
    DOUT = data;
    W    = 1'b1;
    @(posedge Clock);
    #1;
    W    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic readReg(input logic [15:0] addr);
    ADDR = addr;
    #1;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    Resetn = 1'b0;
    ADDR   = 16'h0000;
    DOUT   = 16'h0000;
    W      = 1'b0;

    #5;
    checkOutput("reset_done", {15'd0, Done}, 16'h0000);
    readReg(A_LOAD);
    checkOutput("reset_load", Q, 16'h0000);
    readReg(A_CTRL);
    checkOutput("reset_ctrl", Q, 16'h0000);
    @(negedge Clock);
    Resetn = 1'b1;
    waitEdges(2);

    // One-shot: LOAD=3, CTRL=1
    applyStimulus(A_LOAD, 16'd3);
    applyStimulus(A_CTRL, 16'h0001);
    readReg(A_COUNT);
    checkOutput("os_count_start", Q, 16'd3);
    waitEdges(3);
    checkOutput("os_count_pre_tick", Q, 16'd3);
    waitEdges(1);
    checkOutput("os_count_t4", Q, 16'd2);
    waitEdges(4);
    checkOutput("os_count_t8", Q, 16'd1);
    checkOutput("os_done_t8", {15'd0, Done}, 16'h0000);
    waitEdges(4);
    checkOutput("os_count_t12", Q, 16'd0);
    checkOutput("os_done_t12", {15'd0, Done}, 16'h0001);
    readReg(A_CTRL);
    checkOutput("os_ctrl_cleared", Q, 16'h0000);
    readReg(A_STATUS);
    checkOutput("os_status", Q, 16'h0001);
    waitEdges(8);
    readReg(A_COUNT);
    checkOutput("os_count_hold", Q, 16'd0);

    // Auto-reload: LOAD=2, CTRL=3
    applyStimulus(A_STATUS, 16'h0000);
    checkOutput("st_clear", {15'd0, Done}, 16'h0000);
    applyStimulus(A_LOAD, 16'd2);
    applyStimulus(A_CTRL, 16'h0003);
    waitEdges(4);
    readReg(A_COUNT);
    checkOutput("ar_count_t4", Q, 16'd1);
    waitEdges(4);
    checkOutput("ar_count_reload", Q, 16'd2);
    checkOutput("ar_done_t8", {15'd0, Done}, 16'h0001);
    applyStimulus(A_STATUS, 16'hFFFF);
    checkOutput("ar_done_cleared", {15'd0, Done}, 16'h0000);
    waitEdges(7);
    readReg(A_COUNT);
    checkOutput("ar_done_t16", {15'd0, Done}, 16'h0001);
    checkOutput("ar_count_t16", Q, 16'd2);
    readReg(A_CTRL);
    checkOutput("ar_ctrl_running", Q, 16'h0003);

    // Collisions: STATUS write on the E24 expiry edge, LOAD=7 on the E28 tick edge
    waitEdges(7);
    applyStimulus(A_STATUS, 16'h0000);
    checkOutput("col_status_set_wins", {15'd0, Done}, 16'h0001);
    readReg(A_COUNT);
    checkOutput("col_count_e24", Q, 16'd2);
    waitEdges(3);
    applyStimulus(A_LOAD, 16'd7);
    readReg(A_COUNT);
    checkOutput("col_load_wins", Q, 16'd7);
    waitEdges(3);
    checkOutput("col_count_after", Q, 16'd7);
    waitEdges(1);
    checkOutput("col_count_next_tick", Q, 16'd6);
    applyStimulus(A_CTRL, 16'h0000);
    readReg(A_CTRL);
    checkOutput("stop_ctrl", Q, 16'h0000);

    // Decode and aliasing
    applyStimulus(16'h1000, 16'h1234);
    readReg(16'h1000);
    checkOutput("dec_cs_off", {15'd0, cs}, 16'h0000);
    checkOutput("dec_q_zero", Q, 16'h0000);
    readReg(A_LOAD);
    checkOutput("dec_load_kept", Q, 16'd7);
    applyStimulus(16'h4FF0, 16'hABCD);
    readReg(A_LOAD);
    checkOutput("alias_load", Q, 16'hABCD);
    readReg(A_COUNT);
    checkOutput("alias_count", Q, 16'hABCD);
    readReg(16'h4FF0);
    checkOutput("alias_read", Q, 16'hABCD);
    checkOutput("alias_cs", {15'd0, cs}, 16'h0001);

`ifdef TIMER_IO_IRQ_EN
    applyStimulus(A_LOAD, 16'd1);
    applyStimulus(A_CTRL, 16'h0007);
    readReg(A_CTRL);
    checkOutput("irq_ctrl_rb", Q, 16'h0007);
    checkOutput("irq_before", {15'd0, Irq}, 16'h0000);
    waitEdges(3);
    checkOutput("irq_pre_tick", {15'd0, Irq}, 16'h0000);
    waitEdges(1);
    checkOutput("irq_rise", {15'd0, Irq}, 16'h0001);
    checkOutput("irq_done_rise", {15'd0, Done}, 16'h0001);
    applyStimulus(A_STATUS, 16'h0000);
    checkOutput("irq_drop", {15'd0, Irq}, 16'h0000);
    applyStimulus(A_CTRL, 16'h0001);
    waitEdges(4);
    checkOutput("irq_ie0_done", {15'd0, Done}, 16'h0001);
    checkOutput("irq_ie0", {15'd0, Irq}, 16'h0000);
`else
    applyStimulus(A_CTRL, 16'h0007);
    readReg(A_CTRL);
    checkOutput("ctrl_ie_masked", Q, 16'h0003);
    applyStimulus(A_CTRL, 16'h0000);
`endif

    // Reset mid-count; Done is left set beforehand so the reset has to clear it
    applyStimulus(A_LOAD, 16'd100);
    applyStimulus(A_CTRL, 16'h0001);
    waitEdges(5);
    checkOutput("rst_done_before", {15'd0, Done}, 16'h0001);
    #3;
    Resetn = 1'b0;
    #1;
    checkOutput("rst_done", {15'd0, Done}, 16'h0000);
    readReg(A_LOAD);
    checkOutput("rst_load", Q, 16'h0000);
    readReg(A_COUNT);
    checkOutput("rst_count", Q, 16'h0000);
    readReg(A_CTRL);
    checkOutput("rst_ctrl", Q, 16'h0000);
    @(negedge Clock);
    Resetn = 1'b1;
    waitEdges(20);
    readReg(A_COUNT);
    checkOutput("post_rst_count", Q, 16'h0000);
    checkOutput("post_rst_done", {15'd0, Done}, 16'h0000);
    readReg(A_CTRL);
    checkOutput("post_rst_ctrl", Q, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
